uart_rx_deframe: RTL and testbench
==================================

# uart_rx_deframe

UART receive deframer sitting directly downstream of the receive line filter. It consumes the filtered, debounced line level and the same oversampling enable tick that drives the filter. It finds the start bit, samples each bit at mid-cell, checks the stop bit, and presents each received character on a valid/ready interface to the host-side logic. Framing, parity and overrun conditions are reported as one-cycle pulses.

## Interface
- `OVERSAMPLE`, 16: `samp_clk` ticks per bit cell; must be even and ≥4.
- `DATA_BITS`, 8: data bits per character, 5..9.
- `PARITY_ODD`, 0: 0 = even parity, 1 = odd; only used with `UART_RX_PARITY_EN`.

- `clk`  in  1  system clock; sole clock.
- `rst`  in  1  reset; synchronous, active-high.
- `samp_clk`  in  1  one-`clk`-wide enable at OVERSAMPLE × baud.
- `rx_in`  in  1  filtered line level; idle high.
- `data`  out  DATA_BITS  received character, LSB = first bit on the wire.
- `valid`  out  1  `data` holds an unconsumed character.
- `ready`  in  1  consumer accepts `data` when `valid && ready`.
- `busy`  out  1  high in any state other than IDLE.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `parity_err`  out  1  one-cycle pulse: parity mismatch; tied 0 without macro.
- `overrun`  out  1  one-cycle pulse: character completed while `valid && !ready`.

## Operation
- States: IDLE, START, DATA, PARITY (macro only), STOP, WAIT_HIGH.
- All state, counter and shift updates happen only on `clk` edges with `samp_clk`=1. The exceptions are the handshake and pulse outputs, which update every `clk`.
- Tick counter: ceil(log2(OVERSAMPLE)) bits. Bit counter: counts to DATA_BITS.
- IDLE: `rx_in`=0 on a tick → START. That tick is tick 0 of the frame.
- START: at tick OVERSAMPLE/2, sample `rx_in`:
  - 1 → false start, return to IDLE with no flag.
  - 0 → go to DATA.
- DATA: data bit n (n=0..DATA_BITS-1) sampled at tick OVERSAMPLE/2 + (n+1)·OVERSAMPLE. It is right-shifted into the shift register at the MSB. After the last bit → PARITY if enabled, else STOP.
- PARITY: one cell, sampled mid-cell like a data bit.
  - Expected value = XOR of data bits, inverted when PARITY_ODD=1.
- STOP: sampled one cell after the last data or parity bit.
  - Sample 1 and no parity error → deliver the character, go to IDLE.
  - Sample 1 with parity error → pulse `parity_err`, discard the character, go to IDLE.
  - Sample 0 → pulse `frame_err`, discard the character (parity is not reported), go to WAIT_HIGH.
- WAIT_HIGH: stay until a tick sees `rx_in`=1, then IDLE. This prevents a break or stuck-low line from retriggering.
- Deliver:
  - `valid`=0, or `valid && ready` in the same cycle → load `data`, `valid`=1. A simultaneous consume and load keeps `valid` high and raises no overrun.
  - `valid && !ready` → pulse `overrun`. The new character is dropped and the old `data` is kept.
- Handshake: `valid && ready` with no new load → `valid`=0 next cycle. `data` holds its value until the next load.
- `rst`: all outputs 0, `data`=0, counters 0, state IDLE. Aborts any frame without pulses. `rst` overrides `samp_clk`.

## Timing
- Without parity, stop sample is at tick OVERSAMPLE/2 + (DATA_BITS+1)·OVERSAMPLE, i.e. tick 152 for 16/8. Parity adds OVERSAMPLE ticks.
- `valid`, `frame_err`, `parity_err` and `overrun` assert on the `clk` edge after the stop-sample tick edge (one `clk` of latency). Pulses last exactly one `clk`.
- `busy` rises on the `clk` edge processing tick 0. It falls on the edge leaving STOP or WAIT_HIGH.
- A new start bit is accepted on the first tick after returning to IDLE. There is no dead time beyond the half stop bit.
- `ready` has no combinational path to any output.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - PARITY state present; frame is start + DATA_BITS + parity + stop.
  - `parity_err` is live.
- Not defined:
  - No PARITY state or parity logic; frame is start + DATA_BITS + stop.
  - `parity_err` tied 0; `PARITY_ODD` is ignored.

## Test plan
- Clean receive: OVERSAMPLE=16, `samp_clk` every 4 `clk`, `ready`=1, send 0x55 then 0xA3 back-to-back → `data`=0x55 then 0xA3. `valid` high one cycle each, first one `clk` after tick 152. No error pulses.
- False start: `rx_in` low for 4 ticks, then high → stays in IDLE, `busy` back to 0 after tick 8. No `valid`, no flags.
- Framing error and break: send 0x7E with stop=0, then hold low 40 ticks, then high, then send 0x12 → one `frame_err` pulse, no `valid` for 0x7E, no spurious starts during the hold, 0x12 received.
- Overrun: `ready`=0, send 0x01 then 0x02 → `data`=0x01 and `valid` stays high, `overrun` pulses once at the second stop. Then raise `ready` in the cycle the third character 0x03 completes → `data`=0x03, `valid` stays high, no overrun.
- Parity (macro defined, PARITY_ODD=0): 0x07 with parity bit 1 → delivered. 0x07 with parity bit 0 → `parity_err` pulse, no `valid`.
- Reset mid-frame: assert `rst` for 1 `clk` at tick 60 of a frame → all outputs 0, state IDLE. Remainder of that frame yields no `valid`. Next clean frame 0xC4 is received correctly.

Source files
------------

// File: rtl/uart_rx_deframe.sv
// uart_rx_deframe: UART receive deframer.
// Finds the start bit on the filtered line, samples each bit at mid-cell on
// the oversampling tick, checks the stop bit and presents each character on
// a valid/ready port. Framing, parity and overrun are one-clk pulses.
// Optional feature macro: UART_RX_PARITY_EN adds a parity cell after the
// data bits and makes parity_err live. Without it, parity_err is tied low.
module uart_rx_deframe #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 samp_clk,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 busy,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  // Tick counter value seen on the tick that lands at mid start bit
  localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
  // Tick counter value seen on the tick that lands one cell later
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  state_t               state_q, state_d;
  logic [TW-1:0]        tick_q, tick_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  // Stop-sample outcomes, registered so outputs appear one clk later
  logic                 load_q, load_d;
  logic                 ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
  logic                 par_bad_q, par_bad_d;
  logic                 perr_q, perr_d;
`endif

  assign busy = (state_q != S_IDLE);

  // State, counters, shift register and stop-sample outcome registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      load_q  <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      load_q  <= load_d;
      ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= par_bad_d;
      perr_q    <= perr_d;
`endif
    end
  end

  // Next-state logic; everything advances only on samp_clk ticks
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    load_d  = 1'b0;
    ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
    perr_d    = 1'b0;
`endif
    if (samp_clk) begin
      case (state_q)
        S_IDLE: begin
          if (!rx_in) begin
            // This tick is tick 0 of the frame
            state_d = S_START;
            tick_d  = '0;
            bit_d   = '0;
`ifdef UART_RX_PARITY_EN
            par_bad_d = 1'b0;
`endif
          end
        end
        S_START: begin
          if (tick_q == TICK_HALF) begin
            tick_d  = '0;
            state_d = rx_in ? S_IDLE : S_DATA;
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
        S_DATA: begin
          if (tick_q == TICK_LAST) begin
            tick_d  = '0;
            shift_d = {rx_in, shift_q[DATA_BITS-1:1]};
            bit_d   = bit_q + BW'(1);
            if (bit_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_d = S_PARITY;
`else
              state_d = S_STOP;
`endif
            end
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (tick_q == TICK_LAST) begin
            tick_d    = '0;
            par_bad_d = ((^shift_q) ^ (PARITY_ODD != 0)) != rx_in;
            state_d   = S_STOP;
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
`endif
        S_STOP: begin
          if (tick_q == TICK_LAST) begin
            tick_d = '0;
            if (rx_in) begin
              state_d = S_IDLE;
`ifdef UART_RX_PARITY_EN
              perr_d = par_bad_q;
              load_d = !par_bad_q;
`else
              load_d = 1'b1;
`endif
            end else begin
              // Framing error wins; parity is not reported
              ferr_d  = 1'b1;
              state_d = S_WAIT_HIGH;
            end
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
        S_WAIT_HIGH: begin
          if (rx_in) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output port. A character transfers on any clk where valid && ready.
  // valid stays high until consumed; data is stable while valid is high.
  // A new character loads when the port is empty or being consumed in the
  // same clk; otherwise it is dropped and overrun pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      frame_err <= ferr_q;
      overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= perr_q;
`endif
      if (load_q) begin
        if (!valid || ready) begin
          data  <= shift_q;
          valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

`ifndef UART_RX_PARITY_EN
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_deframe.sv
// Testbench for uart_rx_deframe (OVERSAMPLE=16, DATA_BITS=8, even parity).
// Builds with or without UART_RX_PARITY_EN; parity cases run only with it.
module tb_uart_rx_deframe;

  localparam int OS = 16;
  localparam int DB = 8;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst;
  logic          samp_clk;
  logic          rx_in;
  logic          ready;
  logic [DB-1:0] data;
  logic          valid;
  logic          busy;
  logic          frame_err;
  logic          parity_err;
  logic          overrun;

  always #5 clk = ~clk;

  // samp_clk: one clk high out of every four
  initial begin
    int phase;
    phase    = 0;
    samp_clk = 1'b0;
    forever begin
      @(negedge clk);
      samp_clk = (phase == 3);
      phase    = (phase + 1) % 4;
    end
  end

  uart_rx_deframe #(
    .OVERSAMPLE(OS),
    .DATA_BITS (DB),
    .PARITY_ODD(0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .samp_clk  (samp_clk),
    .rx_in     (rx_in),
    .data      (data),
    .valid     (valid),
    .ready     (ready),
    .busy      (busy),
    .frame_err (frame_err),
    .parity_err(parity_err),
    .overrun   (overrun)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
`ifdef UART_RX_PARITY_EN
  logic par_flip = 1'b0;
`endif

  task automatic wait_tick();
    do @(posedge clk); while (!samp_clk);
    #1;
  endtask

  // Hold the line at lvl for n oversampling ticks
  task automatic drive(input logic lvl, input int n);
    rx_in = lvl;
    repeat (n) wait_tick();
  endtask

  // Start bit, data bits LSB first, and the parity cell when enabled
  task automatic send_head(input logic [DB-1:0] d);
    drive(1'b0, OS);
    for (int i = 0; i < DB; i++) drive(d[i], OS);
`ifdef UART_RX_PARITY_EN
    drive((^d) ^ par_flip, OS);
`endif
  endtask

  task automatic send_frame(input logic [DB-1:0] d, input logic stop_bit);
    send_head(d);
    drive(stop_bit, OS);
  endtask

  // ---------------- scoreboard / monitor ----------------
  logic [DB-1:0] exp_q[$];
  int spur_cnt = 0;
  int fe_cnt   = 0;
  int pe_cnt   = 0;
  int ov_cnt   = 0;
  logic v_prev = 1'b0;
  logic r_prev = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      v_prev = 1'b0;
      r_prev = 1'b0;
    end else begin
      // A fresh character: port was empty or consumed on the last edge
      if (valid && (!v_prev || r_prev)) begin
        if (exp_q.size() == 0) spur_cnt++;
        else check_eq("data", data, exp_q.pop_front());
      end
      if (frame_err)  fe_cnt++;
      if (parity_err) pe_cnt++;
      if (overrun)    ov_cnt++;
      v_prev = valid;
      r_prev = ready;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int exp_pe;
    exp_pe = 0;
    rst   = 1'b1;
    rx_in = 1'b1;
    ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_valid", valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_data", data, 0);
    check_eq("rst_pulses", {frame_err, parity_err, overrun}, 0);
    rst = 1'b0;
    drive(1'b1, 4);

    // Clean receive, with exact latency on the first character
    exp_q.push_back(8'h55);
    send_head(8'h55);
    drive(1'b1, OS / 2);
    wait_tick();                       // stop-sample tick
    check_eq("lat_pre", valid, 0);
    @(posedge clk); #1;
    check_eq("lat_valid", valid, 1);
    check_eq("lat_data", data, 8'h55);
    @(posedge clk); #1;
    check_eq("valid_drop", valid, 0);
    drive(1'b1, OS / 2 - 1);
    exp_q.push_back(8'hA3);
    send_frame(8'hA3, 1'b1);
    drive(1'b1, 4);
    check_eq("clean_q", exp_q.size(), 0);

    // False start
    drive(1'b0, 4);
    drive(1'b1, 4);
    check_eq("fs_busy_hi", busy, 1);
    wait_tick();
    check_eq("fs_busy_lo", busy, 0);
    drive(1'b1, 8);

    // Framing error, then a held break, then a good character
    send_frame(8'h7E, 1'b0);
    drive(1'b0, 40);
    check_eq("brk_busy", busy, 1);
    check_eq("brk_fe", fe_cnt, 1);
    drive(1'b1, 2);
    check_eq("brk_idle", busy, 0);
    drive(1'b1, 8);
    exp_q.push_back(8'h12);
    send_frame(8'h12, 1'b1);
    drive(1'b1, 4);
    check_eq("brk_q", exp_q.size(), 0);

    // Overrun, then a load coinciding with a consume
    ready = 1'b0;
    exp_q.push_back(8'h01);
    send_frame(8'h01, 1'b1);
    send_frame(8'h02, 1'b1);
    drive(1'b1, 4);
    check_eq("ovr_data", data, 8'h01);
    check_eq("ovr_valid", valid, 1);
    check_eq("ovr_cnt", ov_cnt, 1);
    exp_q.push_back(8'h03);
    send_head(8'h03);
    drive(1'b1, OS / 2);
    wait_tick();
    ready = 1'b1;
    @(posedge clk); #1;
    check_eq("swap_data", data, 8'h03);
    check_eq("swap_valid", valid, 1);
    drive(1'b1, OS / 2 - 1);
    check_eq("swap_ovr", ov_cnt, 1);
    check_eq("swap_q", exp_q.size(), 0);

`ifdef UART_RX_PARITY_EN
    // Even parity: good parity delivers, bad parity flags and discards
    exp_q.push_back(8'h07);
    par_flip = 1'b0;
    send_frame(8'h07, 1'b1);
    par_flip = 1'b1;
    send_frame(8'h07, 1'b1);
    par_flip = 1'b0;
    drive(1'b1, 4);
    exp_pe = 1;
    check_eq("par_cnt", pe_cnt, exp_pe);
    check_eq("par_q", exp_q.size(), 0);
`endif

    // Reset at tick 60 of a frame, with a character still pending
    ready = 1'b0;
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1);
    drive(1'b1, 4);
    check_eq("pre_rst_valid", valid, 1);
    drive(1'b0, OS);                   // start bit
    drive(1'b0, OS);                   // bit 0 of 0xFE
    drive(1'b1, 28);                   // ticks 32..59
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("mid_rst_valid", valid, 0);
    check_eq("mid_rst_data", data, 0);
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_pulses", {frame_err, parity_err, overrun}, 0);
    drive(1'b1, 100);                  // remainder of the aborted frame
    ready = 1'b1;
    exp_q.push_back(8'hC4);
    send_frame(8'hC4, 1'b1);
    drive(1'b1, 4);

    // Final tallies
    check_eq("final_q", exp_q.size(), 0);
    check_eq("final_spur", spur_cnt, 0);
    check_eq("final_fe", fe_cnt, 1);
    check_eq("final_pe", pe_cnt, exp_pe);
    check_eq("final_ov", ov_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
